// File: rtl/bcd_pkg.sv
// Shared types and elaboration-time helpers for the sequential binary-to-BCD converter.
package bcd_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_e;

   // ceil(w * log10(2)) in integer form; 30103/100000 approximates log10(2).
   function automatic int digits_for(input int w);
      return (w * 32'sd30103 + 32'sd99999) / 32'sd100000;
   endfunction

   function automatic int cnt_width(input int w);
      return (w > 32'sd1) ? $clog2(w) : 32'sd1;
   endfunction

endpackage

// File: rtl/bcd_seq_converter_if.sv
// Start/ready/done handshake plus result bus between the datapath and the display driver.
interface bcd_seq_converter_if #(
   parameter int BIN_W  = 16,
   parameter int DIGITS = 5
);
   logic                  start;
   logic [BIN_W-1:0]      binary;
   logic                  ready;
   logic                  done;
   logic [4*DIGITS-1:0]   bcd;
   logic                  overflow;

   modport master (output start, output binary,
                   input  ready, input done, input bcd, input overflow);
   modport slave  (input  start, input binary,
                   output ready, output done, output bcd, output overflow);
endinterface

// File: rtl/bcd_digit_adj.sv
// Double-dabble digit correction: add 3 to a BCD digit of 5 or more before the shift.
module bcd_digit_adj (
   input  logic [3:0] digit_i,
   output logic [3:0] digit_o
);

   // Add-3 correction, 4-bit arithmetic.
   always_comb begin
      if (digit_i >= 4'd5) begin
         digit_o = digit_i + 4'd3;
      end else begin
         digit_o = digit_i;
      end
   end

endmodule

// File: rtl/bcd_seq_converter.sv
// Bit-serial binary-to-BCD converter: one input bit per clock, results held in output registers.
module bcd_seq_converter
   import bcd_pkg::*;
#(
   parameter int BIN_W  = 16,
   parameter int DIGITS = 5
) (
   input  logic              clk,
   input  logic              rst,
   bcd_seq_converter_if.slave bus
);

   localparam int CW = cnt_width(BIN_W);
   localparam int DW = 4 * DIGITS;
   localparam logic [CW-1:0] CNT_LOAD = CW'(BIN_W - 1);

   state_e          state_q, state_d;
   logic [BIN_W-1:0] sr_q, sr_d;
   logic [DW-1:0]   dig_q, dig_d;
   logic [DW-1:0]   adj_s, shifted_s;
   logic            ovf_acc_q, ovf_acc_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [DW-1:0]   bcd_q, bcd_d;
   logic            ovf_q, ovf_d;

   for (genvar i = 0; i < DIGITS; i++) begin : g_adj
      bcd_digit_adj u_adj (
         .digit_i (dig_q[4*i +: 4]),
         .digit_o (adj_s[4*i +: 4])
      );
   end

   // Adjusted digits shift left; the shift register MSB enters digit 0 bit 0.
   assign shifted_s = {adj_s[DW-2:0], sr_q[BIN_W-1]};

   // Next-state and datapath update for IDLE/SHIFT/DONE.
   always_comb begin
      state_d   = state_q;
      sr_d      = sr_q;
      dig_d     = dig_q;
      ovf_acc_d = ovf_acc_q;
      cnt_d     = cnt_q;
      bcd_d     = bcd_q;
      ovf_d     = ovf_q;
      case (state_q)
         ST_IDLE: begin
            if (bus.start) begin
               sr_d      = bus.binary;
               dig_d     = '0;
               ovf_acc_d = 1'b0;
               cnt_d     = CNT_LOAD;
               state_d   = ST_SHIFT;
            end else begin
               state_d   = ST_IDLE;
            end
         end
         ST_SHIFT: begin
            sr_d      = sr_q << 1'b1;
            dig_d     = shifted_s;
            ovf_acc_d = ovf_acc_q | adj_s[DW-1];
            if (cnt_q == '0) begin
               // Results become visible only once the last bit is in.
               bcd_d   = shifted_s;
               ovf_d   = ovf_acc_q | adj_s[DW-1];
               state_d = ST_DONE;
            end else begin
               cnt_d   = cnt_q - CW'(1);
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         sr_q      <= '0;
         dig_q     <= '0;
         ovf_acc_q <= 1'b0;
         cnt_q     <= '0;
         bcd_q     <= '0;
         ovf_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         sr_q      <= sr_d;
         dig_q     <= dig_d;
         ovf_acc_q <= ovf_acc_d;
         cnt_q     <= cnt_d;
         bcd_q     <= bcd_d;
         ovf_q     <= ovf_d;
      end
   end

   assign bus.ready    = (state_q == ST_IDLE);
   assign bus.done     = (state_q == ST_DONE);
   assign bus.bcd      = bcd_q;
   assign bus.overflow = ovf_q;

endmodule

// File: tb/tb_bcd_seq_converter.sv
// Self-checking bench: four converter configurations against an arithmetic decimal reference.
module tb_bcd_seq_converter;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int tests_run    = 0;
   int tests_failed = 0;

   logic        rst_s   [4];
   logic        start_s [4];
   logic [15:0] bin_s   [4];
   logic        rdy_s   [4];
   logic        done_s  [4];
   logic        ovf_s   [4];
   logic [19:0] bcd_s   [4];

   bcd_seq_converter_if #(.BIN_W(16), .DIGITS(5)) if0 ();
   bcd_seq_converter_if #(.BIN_W(16), .DIGITS(4)) if1 ();
   bcd_seq_converter_if #(.BIN_W(8),  .DIGITS(3)) if2 ();
   bcd_seq_converter_if #(.BIN_W(1),  .DIGITS(1)) if3 ();

   bcd_seq_converter #(.BIN_W(16), .DIGITS(5)) u_dut0 (.clk(clk), .rst(rst_s[0]), .bus(if0));
   bcd_seq_converter #(.BIN_W(16), .DIGITS(4)) u_dut1 (.clk(clk), .rst(rst_s[1]), .bus(if1));
   bcd_seq_converter #(.BIN_W(8),  .DIGITS(3)) u_dut2 (.clk(clk), .rst(rst_s[2]), .bus(if2));
   bcd_seq_converter #(.BIN_W(1),  .DIGITS(1)) u_dut3 (.clk(clk), .rst(rst_s[3]), .bus(if3));

   assign if0.start = start_s[0];  assign if0.binary = bin_s[0];
   assign if1.start = start_s[1];  assign if1.binary = bin_s[1];
   assign if2.start = start_s[2];  assign if2.binary = bin_s[2][7:0];
   assign if3.start = start_s[3];  assign if3.binary = bin_s[3][0];

   assign rdy_s[0] = if0.ready;  assign done_s[0] = if0.done;  assign ovf_s[0] = if0.overflow;
   assign rdy_s[1] = if1.ready;  assign done_s[1] = if1.done;  assign ovf_s[1] = if1.overflow;
   assign rdy_s[2] = if2.ready;  assign done_s[2] = if2.done;  assign ovf_s[2] = if2.overflow;
   assign rdy_s[3] = if3.ready;  assign done_s[3] = if3.done;  assign ovf_s[3] = if3.overflow;
   assign bcd_s[0] = if0.bcd;
   assign bcd_s[1] = {4'b0, if1.bcd};
   assign bcd_s[2] = {8'b0, if2.bcd};
   assign bcd_s[3] = {16'b0, if3.bcd};

   function automatic int bw_of(input int d);
      case (d)
         0, 1:    return 16;
         2:       return 8;
         default: return 1;
      endcase
   endfunction

   function automatic int dg_of(input int d);
      case (d)
         0:       return 5;
         1:       return 4;
         2:       return 3;
         default: return 1;
      endcase
   endfunction

   // Decimal digits of v, keeping only the lowest 'digits' of them.
   function automatic logic [19:0] ref_bcd(input int unsigned v, input int digits);
      logic [19:0] r;
      int unsigned x;
      r = '0;
      x = v;
      for (int i = 0; i < digits; i++) begin
         r[4*i +: 4] = 4'(x % 10);
         x = x / 10;
      end
      return r;
   endfunction

   function automatic logic ref_ovf(input int unsigned v, input int digits);
      int unsigned lim;
      lim = 1;
      for (int i = 0; i < digits; i++) lim = lim * 10;
      return v >= lim;
   endfunction

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // One full conversion on DUT d with latency, result and handshake checks.
   task automatic run_conv(input int d, input int unsigned v, input string tag);
      int n;
      n = 0;
      while (!rdy_s[d] && n < 100) begin
         @(negedge clk);
         n++;
      end
      check_eq({tag, " ready_before"}, 32'(rdy_s[d]), 32'd1);
      start_s[d] = 1'b1;
      bin_s[d]   = 16'(v);
      @(posedge clk);
      @(negedge clk);
      start_s[d] = 1'b0;
      bin_s[d]   = 16'($urandom);
      check_eq({tag, " busy"}, 32'(rdy_s[d]), 32'd0);
      n = 0;
      while (!done_s[d] && n < 40) begin
         @(negedge clk);
         n++;
      end
      check_eq({tag, " latency"}, 32'(n), 32'(bw_of(d)));
      check_eq({tag, " bcd"}, 32'(bcd_s[d]), 32'(ref_bcd(v, dg_of(d))));
      check_eq({tag, " ovf"}, 32'(ovf_s[d]), 32'(ref_ovf(v, dg_of(d))));
      @(negedge clk);
      check_eq({tag, " done_pulse"}, 32'(done_s[d]), 32'd0);
      check_eq({tag, " ready_after"}, 32'(rdy_s[d]), 32'd1);
   endtask

   initial begin
      int n;
      int dones;
      int last;
      int cycles;
      int unsigned v;
      int unsigned e;
      int unsigned q[$];

      for (int d = 0; d < 4; d++) begin
         rst_s[d] = 1'b1; start_s[d] = 1'b0; bin_s[d] = 16'd0;
      end
      repeat (3) @(negedge clk);
      for (int d = 0; d < 4; d++) rst_s[d] = 1'b0;
      @(negedge clk);
      for (int d = 0; d < 4; d++) begin
         check_eq($sformatf("rst%0d ready", d), 32'(rdy_s[d]), 32'd1);
         check_eq($sformatf("rst%0d done", d),  32'(done_s[d]), 32'd0);
         check_eq($sformatf("rst%0d bcd", d),   32'(bcd_s[d]), 32'd0);
         check_eq($sformatf("rst%0d ovf", d),   32'(ovf_s[d]), 32'd0);
      end

      run_conv(0, 0, "d0_zero");
      run_conv(0, 65535, "d0_max");
      for (int i = 0; i < 6; i++) run_conv(0, $urandom_range(0, 65535), $sformatf("d0_rand%0d", i));

      run_conv(1, 9999,  "d1_9999");
      run_conv(1, 12345, "d1_12345");
      run_conv(1, 10000, "d1_10000");
      for (int i = 0; i < 6; i++) run_conv(1, $urandom_range(0, 65535), $sformatf("d1_rand%0d", i));

      // Start while busy is ignored.
      start_s[0] = 1'b1; bin_s[0] = 16'd1234;
      @(posedge clk);
      @(negedge clk);
      start_s[0] = 1'b0; bin_s[0] = 16'd0;
      repeat (4) @(negedge clk);
      start_s[0] = 1'b1; bin_s[0] = 16'd999;
      @(negedge clk);
      start_s[0] = 1'b0;
      n = 5;
      while (!done_s[0] && n < 40) begin
         @(negedge clk);
         n++;
      end
      check_eq("busy_start latency", 32'(n), 32'd16);
      check_eq("busy_start bcd", 32'(bcd_s[0]), 32'h01234);
      @(negedge clk);
      check_eq("busy_start ready_after", 32'(rdy_s[0]), 32'd1);
      check_eq("busy_start no_requeue", 32'(done_s[0]), 32'd0);
      run_conv(0, 999, "d0_999");

      // Reset mid-conversion aborts without a done pulse.
      start_s[0] = 1'b1; bin_s[0] = 16'd4321;
      @(posedge clk);
      @(negedge clk);
      start_s[0] = 1'b0;
      repeat (7) @(negedge clk);
      rst_s[0] = 1'b1;
      @(negedge clk);
      rst_s[0] = 1'b0;
      check_eq("abort ready", 32'(rdy_s[0]), 32'd1);
      check_eq("abort bcd",   32'(bcd_s[0]), 32'd0);
      check_eq("abort ovf",   32'(ovf_s[0]), 32'd0);
      dones = 0;
      for (int i = 0; i < 25; i++) begin
         @(negedge clk);
         if (done_s[0]) dones++;
      end
      check_eq("abort no_done", 32'(dones), 32'd0);

      rst_s[0] = 1'b1; start_s[0] = 1'b1; bin_s[0] = 16'd77;
      @(negedge clk);
      rst_s[0] = 1'b0; start_s[0] = 1'b0;
      check_eq("rst_start ready", 32'(rdy_s[0]), 32'd1);
      dones = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (done_s[0] || !rdy_s[0]) dones++;
      end
      check_eq("rst_start idle", 32'(dones), 32'd0);

      // Exhaustive back-to-back sweep with start held high.
      bin_s[2] = 16'd0;
      q.push_back(0);
      v = 1;
      start_s[2] = 1'b1;
      dones = 0; last = 0; cycles = 0;
      while (dones < 256 && cycles < 4000) begin
         @(negedge clk);
         cycles++;
         if (done_s[2]) begin
            e = (q.size() > 0) ? q.pop_front() : 32'hFFFF_FFFF;
            check_eq($sformatf("sweep bcd %0d", e), 32'(bcd_s[2]), 32'(ref_bcd(e, 3)));
            check_eq($sformatf("sweep ovf %0d", e), 32'(ovf_s[2]), 32'd0);
            if (dones > 0) check_eq($sformatf("sweep gap %0d", e), 32'(cycles - last), 32'd10);
            last = cycles;
            dones++;
            if (dones == 256) start_s[2] = 1'b0;
         end
         if (rdy_s[2] && v < 256) begin
            bin_s[2] = 16'(v);
            q.push_back(v);
            v++;
         end
      end
      start_s[2] = 1'b0;
      check_eq("sweep count", 32'(dones), 32'd256);

      run_conv(3, 1, "w1_one");
      run_conv(3, 0, "w1_zero");

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/bcd_seq_converter.md
# bcd_seq_converter

Multi-cycle, parametrised binary-to-BCD converter using the shift-and-add-3 (double-dabble) method. It processes one input bit per clock, so area is independent of input width, at the cost of a fixed latency. A start/ready/done handshake lets it sit between the datapath result bus and the seven-segment display driver. An overflow flag is raised when the configured digit count cannot hold the value.

## Interface
Parameters:
- `BIN_W`, 16: width of the unsigned binary input, 1 or more.
- `DIGITS`, 5: number of BCD output digits, 1 or more. Values below `digits_for(BIN_W)` are legal and enable overflow detection.

Ports:
- `clk`, input, 1: the single clock. All state updates on its rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `start`, input, 1: request a conversion. Sampled only while `ready`=1.
- `binary`, input, `BIN_W`: unsigned operand, captured on the accepting edge.
- `ready`, output, 1: converter is idle and will accept `start`.
- `done`, output, 1: single-cycle pulse. `bcd` and `overflow` are valid from this cycle on.
- `bcd`, output, 4·`DIGITS`: packed digits, most significant digit in the top nibble.
- `overflow`, output, 1: the value exceeded 10^`DIGITS`−1. In that case `bcd` holds the value mod 10^`DIGITS`.

## Operation
- FSM has three states: IDLE, SHIFT and DONE.
  - IDLE: `ready`=1. If `start`=1, it copies `binary` into the shift register, clears the digit accumulator and the overflow accumulator, loads the bit counter with `BIN_W`−1, and goes to SHIFT.
  - SHIFT: on each cycle, every digit of 5 or more gets +3 (4-bit arithmetic). Then the concatenation {digits, shift register} shifts left by one. Shift-register bit `BIN_W`−1 enters digit 0 bit 0.
    - The bit shifted out of the top digit's MSB is ORed into the overflow accumulator.
    - When the counter reaches 0, the final shift is done, the result registers load, and the FSM goes to DONE. Otherwise the counter decrements.
  - DONE: `done`=1 and `ready`=0 for exactly one cycle. The FSM then goes unconditionally to IDLE.
- `bcd` and `overflow` are output registers. They update only on the SHIFT to DONE transition and hold until the next conversion completes. Partial results are never visible.
- `start` while `ready`=0 is ignored; nothing is queued.
- Changes on `binary` after the accepting edge have no effect.
- Reset values: state IDLE, `ready`=1, `done`=0, `bcd`=0, `overflow`=0, internal registers 0.
- `rst` during SHIFT or DONE aborts the conversion. No `done` is emitted, and the outputs return to their reset values on that edge.
- `rst` and `start` in the same cycle: reset wins and `start` is dropped.
- `BIN_W`=1 is legal: SHIFT lasts exactly one cycle.

## Timing
- Call the edge that accepts `start` edge 0.
- SHIFT occupies edges 1 through `BIN_W`.
- `done` is high in the cycle following edge `BIN_W`, and deasserts at edge `BIN_W`+1.
- `ready` is low from edge 0 until edge `BIN_W`+1. A new `start` is first accepted at edge `BIN_W`+2, so throughput is one conversion per `BIN_W`+2 cycles.
- Defaults give a 16-cycle SHIFT phase and 18 cycles start-to-start.
- Critical path: one add-3 compare and add per digit in parallel, followed by the shift mux. There is no carry chain between digits.

## Structure
- Package `bcd_pkg` holds:
  - the state enumeration (IDLE, SHIFT, DONE);
  - the constant function `digits_for(w)`, returning ceil(w·log10 2) computed in integer form, with `digits_for(16)`=5;
  - the counter width function, clog2 of `BIN_W`.
- Sub-module `bcd_digit_adj` is combinational: 4-bit in, 4-bit out, adds 3 when the input is 5 or more. It is instantiated `DIGITS` times through a generate loop.
- The top level contains the FSM, the counter, the shift register, the digit accumulator and the output registers.

## Test plan
- Defaults, `binary`=0 → `done` at edge 16+1, `bcd`=0x00000, `overflow`=0. Then 65535 → `bcd`=0x65535, `overflow`=0.
- `DIGITS`=4: `binary`=9999 → `bcd`=0x9999, `overflow`=0. Then 12345 → `bcd`=0x2345, `overflow`=1. Then 10000 → `bcd`=0x0000, `overflow`=1.
- Defaults: start 1234 and pulse `start` with 999 at edge 5.
  - The second request is ignored and the first completes with 0x01234.
  - `ready` returns high one cycle after `done`. Then 999 → 0x00999.
- Defaults: `rst` at edge 8 of a conversion of 4321.
  - No `done` pulse appears, `bcd`=0, `overflow`=0, and `ready`=1 on the next cycle.
  - `rst` together with `start` leaves the block in IDLE.
- `BIN_W`=8, `DIGITS`=3: run an exhaustive sweep of 0–255 back-to-back, with `start` held high. Check one `done` every 10 cycles and each `bcd` against a reference model.
- `BIN_W`=1, `DIGITS`=1: input 1 → `bcd`=0x1 with `done` at edge 2. Input 0 → 0x0.
